// File: rtl/scoreboard_regfile.sv
// Register file with per-register busy (pending producer) bits and registered reads.
// Reads have 1-cycle latency; BYPASS selects post-update or pre-update read values.
module scoreboard_regfile #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              busy1,
  output logic              busy2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] reserve_reg,
  input  logic              reserve_en
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;

  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [DATA_W-1:0] rdata2_q, rdata2_d;
  logic              busy1_q, busy1_d;
  logic              busy2_q, busy2_d;

  logic wr_act;
  logic rs_act;

  // Index 0 is hardwired: never written or reserved, so it stays at its reset value.
  assign wr_act = reg_write  && (write_reg   != '0);
  assign rs_act = reserve_en && (reserve_reg != '0);

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_act) begin
      regs_d[write_reg] = write_data;
      busy_d[write_reg] = 1'b0;
    end
    // Reserve applied last so a same-index write+reserve leaves the register busy.
    if (rs_act) begin
      busy_d[reserve_reg] = 1'b1;
    end
  end

  always_comb begin
    if (BYPASS) begin
      rdata1_d = regs_d[read_reg1];
      rdata2_d = regs_d[read_reg2];
      busy1_d  = busy_d[read_reg1];
      busy2_d  = busy_d[read_reg2];
    end else begin
      rdata1_d = regs_q[read_reg1];
      rdata2_d = regs_q[read_reg2];
      busy1_d  = busy_q[read_reg1];
      busy2_d  = busy_q[read_reg2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q   <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      busy1_q  <= 1'b0;
      busy2_q  <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      busy_q   <= busy_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      busy1_q  <= busy1_d;
      busy2_q  <= busy2_d;
    end
  end

  assign read_data1 = rdata1_q;
  assign read_data2 = rdata2_q;
  assign busy1      = busy1_q;
  assign busy2      = busy2_q;

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Directed bench: bypass and non-bypass builds driven in lockstep, plus a 32x32 build.
module tb_scoreboard_regfile;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Shared stimulus for the two 16-bit / 4-bit-index builds
  logic        rst;
  logic [3:0]  read_reg1, read_reg2, write_reg, reserve_reg;
  logic [15:0] write_data;
  logic        reg_write, reserve_en;

  logic [15:0] byp_rd1, byp_rd2, nob_rd1, nob_rd2;
  logic        byp_b1, byp_b2, nob_b1, nob_b2;

  // Wide build stimulus
  logic        w_rst;
  logic [4:0]  w_rr1, w_rr2, w_wr, w_rsv;
  logic [31:0] w_wdata;
  logic        w_we, w_rse;
  logic [31:0] w_rd1, w_rd2;
  logic        w_b1, w_b2;

  scoreboard_regfile #(.DATA_W(16), .ADDR_W(4), .BYPASS(1'b1)) u_byp (
    .clk(clk), .rst(rst),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(byp_rd1), .read_data2(byp_rd2),
    .busy1(byp_b1), .busy2(byp_b2),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .reserve_reg(reserve_reg), .reserve_en(reserve_en)
  );

  scoreboard_regfile #(.DATA_W(16), .ADDR_W(4), .BYPASS(1'b0)) u_nob (
    .clk(clk), .rst(rst),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(nob_rd1), .read_data2(nob_rd2),
    .busy1(nob_b1), .busy2(nob_b2),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .reserve_reg(reserve_reg), .reserve_en(reserve_en)
  );

  scoreboard_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) u_wide (
    .clk(clk), .rst(w_rst),
    .read_reg1(w_rr1), .read_reg2(w_rr2),
    .read_data1(w_rd1), .read_data2(w_rd2),
    .busy1(w_b1), .busy2(w_b2),
    .write_reg(w_wr), .write_data(w_wdata), .reg_write(w_we),
    .reserve_reg(w_rsv), .reserve_en(w_rse)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl_idle();
    reg_write  = 1'b0;
    reserve_en = 1'b0;
    write_reg  = 4'd0;
    write_data = 16'h0000;
    reserve_reg = 4'd0;
  endtask

  // Checks port 1 (data, busy) on both 16-bit builds
  task automatic chk_p1(input string tag, input logic [15:0] bd, input logic bb,
                        input logic [15:0] nd, input logic nb);
    check({tag, " byp rd1"}, byp_rd1, bd);
    check({tag, " byp b1"},  byp_b1,  bb);
    check({tag, " nob rd1"}, nob_rd1, nd);
    check({tag, " nob b1"},  nob_b1,  nb);
  endtask

  task automatic chk_p2(input string tag, input logic [15:0] bd, input logic bb,
                        input logic [15:0] nd, input logic nb);
    check({tag, " byp rd2"}, byp_rd2, bd);
    check({tag, " byp b2"},  byp_b2,  bb);
    check({tag, " nob rd2"}, nob_rd2, nd);
    check({tag, " nob b2"},  nob_b2,  nb);
  endtask

  initial begin
    rst = 1'b1;
    read_reg1 = 4'd0;
    read_reg2 = 4'd0;
    ctl_idle();
    w_rst = 1'b1;
    w_rr1 = 5'd0; w_rr2 = 5'd0; w_wr = 5'd0; w_rsv = 5'd0;
    w_wdata = 32'h0; w_we = 1'b0; w_rse = 1'b0;

    // Reset with a write pending: nothing may survive
    reg_write = 1'b1; write_reg = 4'd5; write_data = 16'hAAAA;
    tick();
    check("rst state byp rd1", byp_rd1, 16'h0);
    check("rst state nob b2",  nob_b2,  1'b0);
    rst = 1'b0;
    ctl_idle();
    read_reg1 = 4'd5;
    read_reg2 = 4'd15;
    tick();
    chk_p1("post-rst r5",  16'h0, 1'b0, 16'h0, 1'b0);
    chk_p2("post-rst r15", 16'h0, 1'b0, 16'h0, 1'b0);

    // Write r3 with same-cycle read
    reg_write = 1'b1; write_reg = 4'd3; write_data = 16'hBEEF;
    read_reg1 = 4'd3; read_reg2 = 4'd3;
    tick();
    chk_p1("wr r3 same", 16'hBEEF, 1'b0, 16'h0000, 1'b0);
    chk_p2("wr r3 same p2", 16'hBEEF, 1'b0, 16'h0000, 1'b0);
    ctl_idle();
    tick();
    chk_p1("wr r3 next", 16'hBEEF, 1'b0, 16'hBEEF, 1'b0);

    // r0 ignores writes and reserves
    reg_write = 1'b1; write_reg = 4'd0; write_data = 16'h1234;
    read_reg1 = 4'd0; read_reg2 = 4'd0;
    tick();
    ctl_idle();
    tick();
    chk_p1("r0 after wr", 16'h0, 1'b0, 16'h0, 1'b0);
    reserve_en = 1'b1; reserve_reg = 4'd0;
    tick();
    chk_p2("r0 rsv same", 16'h0, 1'b0, 16'h0, 1'b0);
    ctl_idle();
    tick();
    chk_p2("r0 rsv next", 16'h0, 1'b0, 16'h0, 1'b0);

    // Reserve r7, then write, then write+reserve in one cycle
    reserve_en = 1'b1; reserve_reg = 4'd7;
    read_reg1 = 4'd7; read_reg2 = 4'd3;
    tick();
    chk_p1("rsv r7 same", 16'h0, 1'b1, 16'h0, 1'b0);
    ctl_idle();
    tick();
    chk_p1("rsv r7 next", 16'h0, 1'b1, 16'h0, 1'b1);
    reg_write = 1'b1; write_reg = 4'd7; write_data = 16'h00AA;
    tick();
    chk_p1("wr r7 same", 16'h00AA, 1'b0, 16'h0000, 1'b1);
    ctl_idle();
    tick();
    chk_p1("wr r7 next", 16'h00AA, 1'b0, 16'h00AA, 1'b0);
    reg_write = 1'b1; write_reg = 4'd7; write_data = 16'h00AA;
    reserve_en = 1'b1; reserve_reg = 4'd7;
    tick();
    chk_p1("wr+rsv r7 same", 16'h00AA, 1'b1, 16'h00AA, 1'b0);
    ctl_idle();
    tick();
    chk_p1("wr+rsv r7 next", 16'h00AA, 1'b1, 16'h00AA, 1'b1);

    // Write and reserve on different indices in one cycle
    reg_write = 1'b1; write_reg = 4'd4; write_data = 16'h1111;
    reserve_en = 1'b1; reserve_reg = 4'd5;
    read_reg1 = 4'd4; read_reg2 = 4'd5;
    tick();
    ctl_idle();
    tick();
    chk_p1("indep r4", 16'h1111, 1'b0, 16'h1111, 1'b0);
    chk_p2("indep r5", 16'h0000, 1'b1, 16'h0000, 1'b1);

    // Reset mid-sequence with a write and reserve pending
    reg_write = 1'b1; write_reg = 4'd2; write_data = 16'h5555;
    tick();
    ctl_idle();
    reserve_en = 1'b1; reserve_reg = 4'd9;
    read_reg1 = 4'd2; read_reg2 = 4'd9;
    tick();
    chk_p1("pre-rst r2", 16'h5555, 1'b0, 16'h5555, 1'b0);
    chk_p2("pre-rst r9", 16'h0000, 1'b1, 16'h0000, 1'b0);
    rst = 1'b1;
    reg_write = 1'b1; write_reg = 4'd2; write_data = 16'hFFFF;
    reserve_en = 1'b1; reserve_reg = 4'd9;
    tick();
    chk_p1("in-rst out", 16'h0, 1'b0, 16'h0, 1'b0);
    chk_p2("in-rst out", 16'h0, 1'b0, 16'h0, 1'b0);
    rst = 1'b0;
    ctl_idle();
    tick();
    chk_p1("after rst r2", 16'h0, 1'b0, 16'h0, 1'b0);
    chk_p2("after rst r9", 16'h0, 1'b0, 16'h0, 1'b0);
    read_reg1 = 4'd7; read_reg2 = 4'd5;
    tick();
    chk_p1("after rst r7", 16'h0, 1'b0, 16'h0, 1'b0);
    chk_p2("after rst r5", 16'h0, 1'b0, 16'h0, 1'b0);

    // Wide build: top index, both ports
    w_rst = 1'b0;
    w_we = 1'b1; w_wr = 5'd31; w_wdata = 32'hDEADBEEF;
    w_rr1 = 5'd31; w_rr2 = 5'd31;
    tick();
    check("wide r31 p1 same", w_rd1, 32'hDEADBEEF);
    check("wide r31 p2 same", w_rd2, 32'hDEADBEEF);
    w_we = 1'b0;
    w_rse = 1'b1; w_rsv = 5'd30;
    w_rr2 = 5'd30;
    tick();
    check("wide r31 p1 next", w_rd1, 32'hDEADBEEF);
    check("wide r31 b1",      w_b1,  1'b0);
    check("wide r30 b2",      w_b2,  1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
